// File: rtl/alu_muldiv_seq.sv
// Sequencer in front of the iterative mul/div unit: signed div/mod via magnitudes + result fixup, zero-divisor bypass.
// Latency: accept to o_valid = 2 + (cycles i_u_busy high) + 1; zero-divisor bypass = 1 cycle.
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready; i_flush kills any operation.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_valid/o_ready, i_a, i_b    request handshake and operands
//   i_op                         0 MUL, 1 DIVU, 2 MODU, 3 DIV, 4 MOD, 5-7 MUL
//   o_valid/i_ready, o_d         registered result handshake to writeback
//   i_flush                      kills pending or in-flight operation
//   o_u_a, o_u_b, o_u_mul/div/mod, o_u_submit, o_u_flush   unit operand/control lines
//   i_u_busy, i_u_d              unit status and result
module alu_muldiv_seq #(
    parameter int RW       = 16,
    parameter bit ZDIV_BYP = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [RW-1:0] i_a,
    input  logic [RW-1:0] i_b,
    input  logic [2:0]    i_op,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [RW-1:0] o_d,
    input  logic          i_flush,
    output logic [RW-1:0] o_u_a,
    output logic [RW-1:0] o_u_b,
    output logic          o_u_mul,
    output logic          o_u_div,
    output logic          o_u_mod,
    output logic          o_u_submit,
    output logic          o_u_flush,
    input  logic          i_u_busy,
    input  logic [RW-1:0] i_u_d
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Two's complement negate, wraps mod 2^RW (so the most negative value maps to itself).
    function automatic logic [RW-1:0] neg2(input logic [RW-1:0] x);
        return {RW{1'b0}} - x;
    endfunction

    state_t        state_q, state_d;
    logic          sa_q, sa_d;          // dividend sign (signed ops only)
    logic          sb_q, sb_d;          // divisor sign (signed ops only)
    logic          valid_q, valid_d;
    logic [RW-1:0] d_q, d_d;
    logic [RW-1:0] ua_q, ua_d;
    logic [RW-1:0] ub_q, ub_d;
    logic          mul_q, mul_d;
    logic          div_q, div_d;
    logic          mod_q, mod_d;
    logic          submit_q, submit_d;

    // Request decode
    logic          req_div, req_mod, req_mul, req_sgn, b_zero;
    logic [RW-1:0] a_mag, b_mag;
    logic          res_neg;
    logic [RW-1:0] res_fix;

    always_comb begin
        req_div = (i_op == 3'd1) || (i_op == 3'd3);
        req_mod = (i_op == 3'd2) || (i_op == 3'd4);
        req_mul = !(req_div || req_mod);
        req_sgn = (i_op == 3'd3) || (i_op == 3'd4);
        b_zero  = (i_b == {RW{1'b0}});
        a_mag   = (req_sgn && i_a[RW-1]) ? neg2(i_a) : i_a;
        b_mag   = (req_sgn && i_b[RW-1]) ? neg2(i_b) : i_b;
    end

    // Quotient sign follows sa^sb; remainder sign follows the dividend.
    always_comb begin
        res_neg = (div_q && (sa_q ^ sb_q)) || (mod_q && sa_q);
        res_fix = res_neg ? neg2(i_u_d) : i_u_d;
    end

    assign o_ready   = (state_q == S_IDLE) && !i_flush;
    assign o_u_flush = i_flush;

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        valid_d  = valid_q;
        d_d      = d_q;
        ua_d     = ua_q;
        ub_d     = ub_q;
        mul_d    = mul_q;
        div_d    = div_q;
        mod_d    = mod_q;
        submit_d = submit_q;

        if (i_flush) begin
            // Operands stay as they were; only the op selects and handshakes are dropped.
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            submit_d = 1'b0;
            mul_d    = 1'b0;
            div_d    = 1'b0;
            mod_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        sa_d  = req_sgn && i_a[RW-1];
                        sb_d  = req_sgn && i_b[RW-1];
                        ua_d  = a_mag;
                        ub_d  = b_mag;
                        mul_d = req_mul;
                        div_d = req_div;
                        mod_d = req_mod;
                        if (ZDIV_BYP && (req_div || req_mod) && b_zero) begin
                            // Divide by zero: all-ones quotient, raw dividend as remainder.
                            state_d = S_DONE;
                            valid_d = 1'b1;
                            d_d     = req_div ? {RW{1'b1}} : i_a;
                        end else begin
                            state_d  = S_ISSUE;
                            submit_d = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    submit_d = 1'b0;
                    state_d  = S_WAIT;
                end
                S_WAIT: begin
                    if (!i_u_busy) begin
                        d_d     = res_fix;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        mul_d   = 1'b0;
                        div_d   = 1'b0;
                        mod_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            valid_q  <= 1'b0;
            d_q      <= {RW{1'b0}};
            ua_q     <= {RW{1'b0}};
            ub_q     <= {RW{1'b0}};
            mul_q    <= 1'b0;
            div_q    <= 1'b0;
            mod_q    <= 1'b0;
            submit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            valid_q  <= valid_d;
            d_q      <= d_d;
            ua_q     <= ua_d;
            ub_q     <= ub_d;
            mul_q    <= mul_d;
            div_q    <= div_d;
            mod_q    <= mod_d;
            submit_q <= submit_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_d        = d_q;
    assign o_u_a      = ua_q;
    assign o_u_b      = ub_q;
    assign o_u_mul    = mul_q;
    assign o_u_div    = div_q;
    assign o_u_mod    = mod_q;
    assign o_u_submit = submit_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed vectors, scoreboard queue checked by an independent monitor.
// Includes a behavioural iterative unit with a programmable busy length.
// Inputs driven at negedge, outputs sampled 2 time units later.
module tb_alu_muldiv_seq;

    localparam int RW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [RW-1:0] i_a = '0;
    logic [RW-1:0] i_b = '0;
    logic [2:0]    i_op = '0;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic [RW-1:0] o_d;
    logic          i_flush = 1'b0;
    logic [RW-1:0] o_u_a, o_u_b;
    logic          o_u_mul, o_u_div, o_u_mod, o_u_submit, o_u_flush;
    logic          i_u_busy;
    logic [RW-1:0] i_u_d;

    alu_muldiv_seq #(.RW(RW), .ZDIV_BYP(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_op(i_op),
        .o_valid(o_valid), .i_ready(i_ready), .o_d(o_d),
        .i_flush(i_flush),
        .o_u_a(o_u_a), .o_u_b(o_u_b),
        .o_u_mul(o_u_mul), .o_u_div(o_u_div), .o_u_mod(o_u_mod),
        .o_u_submit(o_u_submit), .o_u_flush(o_u_flush),
        .i_u_busy(i_u_busy), .i_u_d(i_u_d)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural iterative unit ----------------
    int            busy_len = 16;
    int            ucnt;
    logic [RW-1:0] ures;

    function automatic logic [RW-1:0] unit_f(input logic m, input logic dv, input logic md,
                                             input logic [RW-1:0] a, input logic [RW-1:0] b);
        logic [2*RW-1:0] p;
        p = a * b;
        if (dv) return (b == 0) ? {RW{1'b1}} : a / b;
        if (md) return (b == 0) ? a : a % b;
        if (m) return p[RW-1:0];
        return '0;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ucnt <= 0;
            ures <= '0;
        end else if (o_u_flush) begin
            ucnt <= 0;
        end else if (o_u_submit) begin
            ucnt <= busy_len;
            ures <= unit_f(o_u_mul, o_u_div, o_u_mod, o_u_a, o_u_b);
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
        end
    end
    assign i_u_busy = o_u_submit || (ucnt != 0);
    assign i_u_d    = ures;

    // ---------------- submit count / operand stability ----------------
    int            submits = 0;
    int            unstable = 0;
    logic [RW-1:0] ua_lat, ub_lat;
    always @(negedge i_clk) begin
        #2;
        if (o_u_submit) begin
            submits++;
            ua_lat = o_u_a;
            ub_lat = o_u_b;
        end else if (i_u_busy && (o_u_a !== ua_lat || o_u_b !== ub_lat)) begin
            unstable++;
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        string         name;
        logic [RW-1:0] d;
        int            acc;
        int            lat;
    } exp_t;
    exp_t sbq[$];
    exp_t me;
    int   rise_cyc = 0;
    logic prev_vld = 1'b0;

    initial begin
        forever begin
            @(negedge i_clk);
            #2;
            if (!i_rst_n) begin
                prev_vld = 1'b0;
            end else begin
                if (o_valid && !prev_vld) rise_cyc = cyc;
                prev_vld = o_valid;
                if (o_valid && i_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got o_d=0x%0h, expected no o_valid", o_d);
                    end else begin
                        me = sbq.pop_front();
                        check({me.name, "_d"}, 32'(o_d), 32'(me.d));
                        check({me.name, "_lat"}, 32'(rise_cyc - me.acc), 32'(me.lat));
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input string name, input logic [2:0] op, input logic [RW-1:0] a,
                        input logic [RW-1:0] b, input logic expect_out, input logic [RW-1:0] exp_d,
                        input int lat, input logic chk_u, input logic [RW-1:0] eua,
                        input logic [RW-1:0] eub, output int acc);
        exp_t e;
        bit   ok;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_op = op;
        i_a = a;
        i_b = b;
        #2;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            if (o_ready) begin
                ok = 1;
                break;
            end
            @(negedge i_clk);
            #2;
        end
        acc = cyc;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got o_ready=0 for 100 cycles, expected 1", name);
        end else if (expect_out) begin
            e.name = name;
            e.d = exp_d;
            e.acc = acc;
            e.lat = lat;
            sbq.push_back(e);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        #2;
        if (chk_u) begin
            check({name, "_ua"}, 32'(o_u_a), 32'(eua));
            check({name, "_ub"}, 32'(o_u_b), 32'(eub));
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sbq.size() != 0; t++) @(negedge i_clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d results outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1);
    end

    int acc, s0, hold_err;
    logic [RW-1:0] d0;

    initial begin
        // Reset state
        repeat (3) @(negedge i_clk);
        #2;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_d", 32'(o_d), 0);
        check("rst_submit", 32'(o_u_submit), 0);
        check("rst_ua", 32'(o_u_a), 0);
        check("rst_sel", 32'({o_u_mul, o_u_div, o_u_mod}), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #2;
        check("rst_ready", 32'(o_ready), 1);

        // 1: MUL with 16-cycle unit
        busy_len = 16;
        send("mul", 3'd0, 16'h0123, 16'h0045, 1, 16'h4E6F, 19, 1, 16'h0123, 16'h0045, acc);
        drain();
        check("mul_ustable", 32'(unstable), 0);

        // 2: signed div/mod
        busy_len = 3;
        send("div_m7_2", 3'd3, 16'hFFF9, 16'h0002, 1, 16'hFFFD, 6, 1, 16'h0007, 16'h0002, acc);
        drain();
        send("mod_m7_2", 3'd4, 16'hFFF9, 16'h0002, 1, 16'hFFFF, 6, 1, 16'h0007, 16'h0002, acc);
        drain();
        send("mod_7_m2", 3'd4, 16'h0007, 16'hFFFE, 1, 16'h0001, 6, 1, 16'h0007, 16'h0002, acc);
        drain();

        // 3: divide by zero bypass
        s0 = submits;
        send("divu_z", 3'd1, 16'h1234, 16'h0000, 1, 16'hFFFF, 1, 1, 16'h1234, 16'h0000, acc);
        drain();
        send("modu_z", 3'd2, 16'h1234, 16'h0000, 1, 16'h1234, 1, 0, '0, '0, acc);
        drain();
        send("mod_z", 3'd4, 16'hFFF9, 16'h0000, 1, 16'hFFF9, 1, 0, '0, '0, acc);
        drain();
        send("div_z", 3'd3, 16'h8000, 16'h0000, 1, 16'hFFFF, 1, 0, '0, '0, acc);
        drain();
        check("zdiv_no_submit", 32'(submits - s0), 0);

        // 4: boundaries and misc ops
        send("div_ovf", 3'd3, 16'h8000, 16'hFFFF, 1, 16'h8000, 6, 1, 16'h8000, 16'h0001, acc);
        drain();
        send("modu_100_7", 3'd2, 16'd100, 16'd7, 1, 16'd2, 6, 0, '0, '0, acc);
        drain();
        send("divu_big", 3'd1, 16'hFFFF, 16'h0010, 1, 16'h0FFF, 6, 1, 16'hFFFF, 16'h0010, acc);
        drain();
        send("mul_op7", 3'd7, 16'd3, 16'd5, 1, 16'd15, 6, 0, '0, '0, acc);
        drain();

        // 5: flush in WAIT cycle 5, then flush colliding with i_valid
        busy_len = 16;
        send("flushed", 3'd0, 16'd2, 16'd3, 0, '0, 0, 0, '0, '0, acc);
        repeat (5) @(negedge i_clk);
        i_flush = 1'b1;
        #2;
        check("flush_pass", 32'(o_u_flush), 1);
        @(negedge i_clk);
        i_flush = 1'b0;
        #2;
        check("flush_valid", 32'(o_valid), 0);
        check("flush_sel", 32'({o_u_mul, o_u_div, o_u_mod}), 0);
        check("flush_ready", 32'(o_ready), 1);
        repeat (25) @(negedge i_clk);
        s0 = submits;
        i_valid = 1'b1;
        i_flush = 1'b1;
        i_op = 3'd0;
        #2;
        check("flush_vld_ready", 32'(o_ready), 0);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        #2;
        check("flush_vld_sel", 32'({o_u_mul, o_u_div, o_u_mod}), 0);
        @(negedge i_clk);
        #2;
        check("flush_vld_nosub", 32'(submits - s0), 0);
        send("mul_after", 3'd0, 16'h00FF, 16'h0101, 1, 16'hFFFF, 19, 1, 16'h00FF, 16'h0101, acc);
        drain();

        // 6: result held under backpressure
        busy_len = 3;
        i_ready = 1'b0;
        send("divu_hold", 3'd1, 16'd1000, 16'd10, 1, 16'd100, 6, 0, '0, '0, acc);
        for (int t = 0; t < 50 && !o_valid; t++) begin
            @(negedge i_clk);
            #2;
        end
        d0 = o_d;
        hold_err = 0;
        repeat (10) begin
            @(negedge i_clk);
            #2;
            if (o_d !== d0 || o_valid !== 1'b1 || o_ready !== 1'b0) hold_err++;
        end
        check("hold_stable", 32'(hold_err), 0);
        @(negedge i_clk);
        i_ready = 1'b1;
        drain();

        // Async reset mid-WAIT
        busy_len = 16;
        send("rst_op", 3'd0, 16'h1111, 16'h0002, 0, '0, 0, 0, '0, '0, acc);
        repeat (4) @(negedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("arst_ua", 32'(o_u_a), 0);
        check("arst_ub", 32'(o_u_b), 0);
        check("arst_sel", 32'({o_u_mul, o_u_div, o_u_mod, o_u_submit}), 0);
        check("arst_valid", 32'(o_valid), 0);
        check("arst_d", 32'(o_d), 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        busy_len = 3;
        send("modu_post", 3'd2, 16'd100, 16'd7, 1, 16'd2, 6, 0, '0, '0, acc);
        drain();
        repeat (3) @(negedge i_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
